// File: rtl/game_tick_timer_if.sv
// ---------------------------------------------------------------------------
// game_tick_timer_if
// Purpose : groups the game-side signals of game_tick_timer into one bundle.
// Signals :
//   div_clock        divider square wave (sampled in the clk domain)
//   pause            1 = suppress game ticks
//   power_pellet     one-cycle pulse, starts/reloads frightened mode
//   game_tick        one-cycle strobe per accepted div_clock rising edge
//   anim_frame[1:0]  sprite animation frame index, 0..2
//   fright_active    frightened mode active
//   fright_blink     ghost blink phase (meaningful only while warning)
//   fright_remaining[7:0] game ticks left in frightened mode
//   fright_done      one-cycle pulse when frightened mode expires
// Modports:
//   master  game/stimulus side, drives the inputs, observes the outputs
//   slave   timer side
// ---------------------------------------------------------------------------
interface game_tick_timer_if;
  logic       div_clock;
  logic       pause;
  logic       power_pellet;
  logic       game_tick;
  logic [1:0] anim_frame;
  logic       fright_active;
  logic       fright_blink;
  logic [7:0] fright_remaining;
  logic       fright_done;

  modport master (
    output div_clock, pause, power_pellet,
    input  game_tick, anim_frame, fright_active, fright_blink,
           fright_remaining, fright_done
  );

  modport slave (
    input  div_clock, pause, power_pellet,
    output game_tick, anim_frame, fright_active, fright_blink,
           fright_remaining, fright_done
  );
endinterface

// File: rtl/game_tick_timer.sv
// ---------------------------------------------------------------------------
// game_tick_timer
// Purpose : derives the game tick from the divider square wave, steps the
//           sprite animation frame (ping-pong 0,1,2,1) every ANIM_DIV ticks,
//           and times the ghosts' frightened mode started by a power pellet
//           (FRIGHT, then a blinking WARN phase for the last WARN_TICKS).
// Parameters:
//   FRIGHT_TICKS  frightened duration in game ticks       (1..255)
//   WARN_TICKS    remaining count at which WARN starts    (0..FRIGHT_TICKS-1)
//   ANIM_DIV      game ticks per animation frame step     (1..255)
// Ports:
//   clk    system clock, all registers on its rising edge
//   reset  asynchronous, active-low reset
//   bus    game_tick_timer_if.slave (inputs div_clock, pause, power_pellet;
//          outputs game_tick, anim_frame, fright_* )
// ---------------------------------------------------------------------------
module game_tick_timer #(
  parameter int FRIGHT_TICKS = 60,
  parameter int WARN_TICKS   = 20,
  parameter int ANIM_DIV     = 4
) (
  input  logic              clk,
  input  logic              reset,
  game_tick_timer_if.slave  bus
);

  localparam logic [7:0] FRIGHT_LOAD = 8'(FRIGHT_TICKS);
  localparam logic [7:0] WARN_AT     = 8'(WARN_TICKS);
  localparam logic [7:0] ANIM_LAST   = 8'(ANIM_DIV - 1);

  typedef enum logic [1:0] {
    A0 = 2'd0,
    A1 = 2'd1,
    A2 = 2'd2,
    A3 = 2'd3
  } frame_e;

  typedef enum logic [1:0] {
    F_IDLE   = 2'd0,
    F_FRIGHT = 2'd1,
    F_WARN   = 2'd2
  } fright_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic       div_prev_q;
  logic       game_tick_q,  game_tick_d;
  logic [7:0] presc_q,      presc_d;
  frame_e     frame_q,      frame_d;
  fright_e    fright_q,     fright_d;
  logic [7:0] remaining_q,  remaining_d;
  logic       blink_q,      blink_d;
  logic       active_q,     active_d;
  logic       done_q,       done_d;

  logic       rise;
  logic       frame_step;
  logic [7:0] remaining_dec;

  // -------------------------------------------------------------------------
  // Tick generation and animation prescaler / frame FSM (next state)
  // -------------------------------------------------------------------------
  // div_clock is treated as already synchronous to clk, so a single history
  // register is enough for edge detection.
  assign rise = bus.div_clock & ~div_prev_q;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    game_tick_d = rise & ~bus.pause;   // a rise during pause is simply lost
    presc_d     = presc_q;
    frame_step  = 1'b0;

    // The prescaler counts the registered tick, i.e. the strobe the outside
    // world sees, so animation lines up with visible game ticks.
    if (game_tick_q) begin
      if (presc_q == ANIM_LAST) begin
        presc_d    = 8'd0;
        frame_step = 1'b1;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end

    frame_d = frame_q;
    if (frame_step) begin
      unique case (frame_q)
        A0:      frame_d = A1;
        A1:      frame_d = A2;
        A2:      frame_d = A3;
        A3:      frame_d = A0;
        default: frame_d = A0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Fright FSM (next state and registered outputs)
  // -------------------------------------------------------------------------
  assign remaining_dec = remaining_q - 8'd1;

  always_comb begin
    fright_d    = fright_q;
    remaining_d = remaining_q;
    blink_d     = blink_q;
    done_d      = 1'b0;

    if (bus.power_pellet) begin
      // Reload wins over everything, including a coincident tick and pause.
      fright_d    = F_FRIGHT;
      remaining_d = FRIGHT_LOAD;
      blink_d     = 1'b0;
    end else begin
      unique case (fright_q)
        F_IDLE: begin
          remaining_d = 8'd0;
          blink_d     = 1'b0;
        end

        F_FRIGHT: begin
          if (game_tick_q) begin
            remaining_d = remaining_dec;
            // Expiry is tested first so WARN_TICKS=0 goes straight to IDLE.
            if (remaining_dec == 8'd0) begin
              fright_d = F_IDLE;
              done_d   = 1'b1;
            end else if (remaining_dec == WARN_AT) begin
              fright_d = F_WARN;
              blink_d  = 1'b1;
            end
          end
        end

        F_WARN: begin
          if (game_tick_q) begin
            remaining_d = remaining_dec;
            if (remaining_dec == 8'd0) begin
              fright_d = F_IDLE;
              blink_d  = 1'b0;
              done_d   = 1'b1;
            end else begin
              blink_d = ~blink_q;
            end
          end
        end

        default: begin
          fright_d    = F_IDLE;
          remaining_d = 8'd0;
          blink_d     = 1'b0;
        end
      endcase
    end

    active_d = (fright_d != F_IDLE);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_prev_q  <= 1'b1;   // a div_clock already high at release is no edge
      game_tick_q <= 1'b0;
      presc_q     <= 8'd0;
      frame_q     <= A0;
      fright_q    <= F_IDLE;
      remaining_q <= 8'd0;
      blink_q     <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      div_prev_q  <= bus.div_clock;
      game_tick_q <= game_tick_d;
      presc_q     <= presc_d;
      frame_q     <= frame_d;
      fright_q    <= fright_d;
      remaining_q <= remaining_d;
      blink_q     <= blink_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    unique case (frame_q)
      A0:      bus.anim_frame = 2'd0;
      A1:      bus.anim_frame = 2'd1;
      A2:      bus.anim_frame = 2'd2;
      A3:      bus.anim_frame = 2'd1;
      default: bus.anim_frame = 2'd0;
    endcase
  end

  assign bus.game_tick        = game_tick_q;
  assign bus.fright_active    = active_q;
  assign bus.fright_blink     = blink_q;
  assign bus.fright_remaining = remaining_q;
  assign bus.fright_done      = done_q;

endmodule

// File: tb/tb_game_tick_timer.sv
// ---------------------------------------------------------------------------
// tb_game_tick_timer
// Purpose : self-checking bench for game_tick_timer with FRIGHT_TICKS=5,
//           WARN_TICKS=2, ANIM_DIV=2. A cycle-level reference model tracks
//           the game in plain terms (ticks seen, ticks left, pending expiry)
//           and is compared against every output once per clock.
// ---------------------------------------------------------------------------
module tb_game_tick_timer;

  localparam int FT = 5;
  localparam int WT = 2;
  localparam int AD = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  game_tick_timer_if bus ();

  game_tick_timer #(
    .FRIGHT_TICKS (FT),
    .WARN_TICKS   (WT),
    .ANIM_DIV     (AD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: values the outputs must show after the next clock edge.
  int m_prev;          // last sampled div_clock
  int m_tick;          // game_tick strobe
  int m_ticks_total;   // game ticks delivered since reset
  int m_rem;           // ticks left in frightened mode (0 = not frightened)
  int m_done;          // expiry pulse

  int wph = 0;         // divider waveform phase
  int obs_ticks;       // game_tick pulses seen by the bench
  int obs_done;        // fright_done pulses seen by the bench
  bit rec_frames = 0;
  int frames_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_frame();
    int ph;
    ph = (m_ticks_total / AD) % 4;
    return (ph == 0) ? 0 : ((ph == 2) ? 2 : 1);
  endfunction

  // Blink is 1 on reaching WT ticks left and alternates every tick after.
  function automatic int exp_blink();
    if (m_rem > 0 && m_rem <= WT) return ((WT - m_rem) % 2 == 0) ? 1 : 0;
    return 0;
  endfunction

  function automatic logic next_div(input int half);
    logic d;
    d = ((wph % (2 * half)) < half);
    wph++;
    return d;
  endfunction

  task automatic model_reset();
    m_prev = 1; m_tick = 0; m_ticks_total = 0; m_rem = 0; m_done = 0;
  endtask

  task automatic check_all();
    check("game_tick",        bus.game_tick,        m_tick);
    check("anim_frame",       bus.anim_frame,       exp_frame());
    check("fright_active",    bus.fright_active,    (m_rem > 0) ? 1 : 0);
    check("fright_blink",     bus.fright_blink,     exp_blink());
    check("fright_remaining", bus.fright_remaining, m_rem);
    check("fright_done",      bus.fright_done,      m_done);
    if (bus.game_tick === 1'b1) begin
      obs_ticks++;
      if (rec_frames) frames_q.push_back(int'(bus.anim_frame));
    end
    if (bus.fright_done === 1'b1) obs_done++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_game_tick"},  bus.game_tick,        0);
    check({tag, "_anim_frame"}, bus.anim_frame,       0);
    check({tag, "_active"},     bus.fright_active,    0);
    check({tag, "_blink"},      bus.fright_blink,     0);
    check({tag, "_remaining"},  bus.fright_remaining, 0);
    check({tag, "_done"},       bus.fright_done,      0);
  endtask

  // Called at a falling edge: compare, drive this cycle's inputs, predict.
  task automatic step(input logic d, input logic p, input logic pel);
    int nt;
    check_all();
    bus.div_clock    = d;
    bus.pause        = p;
    bus.power_pellet = pel;
    nt = (d && !m_prev && !p) ? 1 : 0;
    m_prev = d;
    if (m_tick != 0) m_ticks_total++;
    if (pel) begin
      m_rem = FT; m_done = 0;
    end else if (m_tick != 0 && m_rem > 0) begin
      m_rem--; m_done = (m_rem == 0) ? 1 : 0;
    end else begin
      m_done = 0;
    end
    m_tick = nt;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int ref_frames[8] = '{0, 0, 1, 1, 2, 2, 1, 1};
    int n;

    bus.div_clock = 1'b0; bus.pause = 1'b0; bus.power_pellet = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("por");
    reset = 1'b1;
    model_reset();

    // Eight divider periods of 8 clk, no pause.
    obs_ticks = 0; rec_frames = 1; wph = 4;   // start in the low half
    for (int i = 0; i < 64; i++) step(next_div(4), 1'b0, 1'b0);
    step(next_div(4), 1'b0, 1'b0);
    rec_frames = 0;
    check("ticks_8_periods", obs_ticks, 8);
    check("frames_recorded", frames_q.size(), 8);
    for (int i = 0; i < 8 && i < frames_q.size(); i++)
      check($sformatf("frame_at_tick%0d", i), frames_q[i], ref_frames[i]);
    check("frame_after_8", bus.anim_frame, 0);

    // Pause spanning two rises; those ticks vanish.
    obs_ticks = 0;
    for (int i = 0; i < 16; i++) step(next_div(4), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(next_div(4), 1'b0, 1'b0);
    check("ticks_after_pause", obs_ticks, 2);

    // Power pellet, then run until expiry.
    obs_done = 0;
    step(next_div(4), 1'b0, 1'b1);
    for (int i = 0; i < 48; i++) step(next_div(4), 1'b0, 1'b0);
    check("done_pulses", obs_done, 1);
    check("active_after_expiry", bus.fright_active, 0);

    // Pellet coincident with a tick while one tick is left.
    step(next_div(4), 1'b0, 1'b1);
    obs_done = 0;
    n = 0;
    while (!(m_tick != 0 && m_rem == 1) && n < 200) begin
      step(next_div(4), 1'b0, 1'b0);
      n++;
    end
    check("reached_rem1_tick", {bus.game_tick, bus.fright_remaining}, {1'b1, 8'd1});
    step(next_div(4), 1'b0, 1'b1);
    check("reload_rem", bus.fright_remaining, FT);
    check("reload_active", bus.fright_active, 1);
    for (int i = 0; i < 4; i++) step(next_div(4), 1'b0, 1'b0);
    check("no_done_on_reload", obs_done, 0);

    // Reset while in WARN.
    n = 0;
    while (!(m_rem > 0 && m_rem <= WT) && n < 200) begin
      step(next_div(4), 1'b0, 1'b0);
      n++;
    end
    check_all();
    check("in_warn_before_reset", bus.fright_blink | (bus.fright_remaining <= WT), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_reset");
    bus.div_clock = 1'b1;
    obs_done = 0;
    @(negedge clk);
    check_all_zero("held_reset");
    reset = 1'b1;
    model_reset();
    obs_ticks = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    check("no_tick_high_release", obs_ticks, 0);
    check("no_done_after_reset", obs_done, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("first_edge_after_reset", obs_ticks, 1);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++)
      step(logic'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 39) == 0));
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_tick_timer.md
GAME_TICK_TIMER -- requirements
Module: game_tick_timer

Interface
REQ-001 Parameter FRIGHT_TICKS, default 60, frightened-mode duration in game ticks; legal range 1..255.
REQ-002 Parameter WARN_TICKS, default 20, remaining-tick count at which the warning phase starts; legal range 0..FRIGHT_TICKS-1.
REQ-003 Parameter ANIM_DIV, default 4, game ticks per animation frame step; legal range 1..255.
REQ-004 clk  in  1  single system clock; every register is clocked on posedge clk.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 div_clock  in  1  square wave from the frequency divider, registered in the clk domain.
REQ-007 pause  in  1  1 = suppress game ticks.
REQ-008 power_pellet  in  1  one-cycle pulse when a power pellet is eaten.
REQ-009 game_tick  out  1  one-cycle strobe per accepted div_clock rising edge.
REQ-010 anim_frame  out  2  sprite animation frame index, 0..2.
REQ-011 fright_active  out  1  frightened mode active (FRIGHT or WARN state).
REQ-012 fright_blink  out  1  ghost blink phase; meaningful only in WARN.
REQ-013 fright_remaining  out  8  game ticks left in frightened mode.
REQ-014 fright_done  out  1  one-cycle pulse when frightened mode expires.

Function
REQ-015 The block SHALL register div_clock into div_prev and detect rise = div_clock & ~div_prev; no synchronizer stage is used.
REQ-016 game_tick SHALL be 1 in the cycle after a cycle with rise=1 and pause=0; latency is exactly 1 clk.
REQ-017 A rise that occurs while pause=1 SHALL be dropped, not queued.
REQ-018 The animation prescaler SHALL count game_tick pulses 0..ANIM_DIV-1; on a game_tick with the prescaler at ANIM_DIV-1, it SHALL wrap to 0 and advance the frame FSM.
REQ-019 The frame FSM SHALL have states A0, A1, A2, A3, with anim_frame values 0, 1, 2, 1 respectively; it advances A0->A1->A2->A3->A0 (ping-pong).
REQ-020 The fright FSM SHALL have states IDLE, FRIGHT, WARN.
REQ-021 A power_pellet=1 in any state SHALL cause, on that edge: state := FRIGHT and remaining := FRIGHT_TICKS. Re-triggering reloads the count, and the reload is accepted even when pause=1.
REQ-022 In FRIGHT or WARN, a cycle with game_tick=1 and power_pellet=0 SHALL set remaining := remaining-1.
REQ-023 If the decremented value is 0, the FSM SHALL go to IDLE and pulse fright_done in the next cycle. This transition has priority over the WARN transition.
REQ-024 If the decremented value equals WARN_TICKS and is nonzero, the FSM SHALL move from FRIGHT to WARN.
REQ-025 If power_pellet and game_tick coincide, the reload SHALL win; no decrement occurs and no fright_done is produced.
REQ-026 When WARN_TICKS=0, the FSM SHALL skip WARN and go directly FRIGHT->IDLE.
REQ-027 fright_blink SHALL be set to 1 on entry to WARN, toggle on each later game_tick while in WARN, and be 0 in IDLE and FRIGHT.
REQ-028 fright_active, fright_remaining and fright_blink SHALL be registered and update on the same edge as the state change.
REQ-029 fright_remaining SHALL be 0 in IDLE and SHALL never wrap below 0.

Reset
REQ-030 While reset=0, all state SHALL clear asynchronously: div_prev=1 (a high div_clock at reset release gives no tick), prescaler=0, frame FSM=A0, fright FSM=IDLE.
REQ-031 While reset=0, all outputs SHALL be 0: game_tick, anim_frame, fright_active, fright_blink, fright_remaining, fright_done.
REQ-032 Reset asserted mid-fright SHALL abort the fright immediately with no fright_done pulse.
REQ-033 After reset release, the block SHALL resume on the first qualifying edge.

Verification (FRIGHT_TICKS=5, WARN_TICKS=2, ANIM_DIV=2)
REQ-034 Scenario: div_clock period 8 clk, pause=0, 8 rising edges -> 8 game_tick pulses, each 1 clk after its rise; anim_frame sequence 0,0,1,1,2,2,1,1 then 0.
REQ-035 Scenario: pause=1 spanning 2 rises, then pause=0 -> those 2 ticks are absent, and the prescaler and frame do not advance for them.
REQ-036 Scenario: power_pellet, then 5 ticks -> remaining goes 5,4,3,2(WARN, blink=1),1(blink=0),0; fright_done pulses once; fright_active=0.
REQ-037 Scenario: power_pellet coincident with a tick while remaining=1 -> remaining=5, state FRIGHT, no fright_done.
REQ-038 Scenario: reset pulse while in WARN -> all outputs 0 immediately; no fright_done pulse; div_clock held high at release gives no tick.
